// File: rtl/bf16_pkg.sv
// Shared constants and types for the bfloat16 tanh LUT loader.
package bf16_pkg;
  localparam int BF16_W         = 16;
  localparam int LUT_AW         = 5;
  localparam int ENTRY_SIZE_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_READY = 2'd3
  } state_t;

  typedef struct packed {
    logic [LUT_AW-1:0] addr;
    logic [BF16_W-1:0] data;
  } lut_entry_t;
endpackage

// File: rtl/bf16_lut_fifo.sv
// Small synchronous FIFO buffering LUT entries between the load stream and the
// LUT write port. Pointers carry one wrap bit to tell full from empty.
module bf16_lut_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;
  logic         w_do_pop;
  logic         w_do_push;

  assign o_empty   = (r_wp == r_rp);
  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A push on a full FIFO is legal only when the same cycle frees a slot.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/bfloat16_lut_loader.sv
// Streams ENTRY_SIZE LUT entries into bfloat16_tanh, then forwards samples.
// Define BF16_LUT_COVER_EN to flag loads that leave LUT addresses unwritten.
module bfloat16_lut_loader
  import bf16_pkg::*;
#(
  parameter int ENTRY_SIZE = ENTRY_SIZE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [LUT_AW-1:0] s_addr,
  input  logic [BF16_W-1:0] s_data,
  input  logic              hold,
  output logic              in_load_enable,
  output logic [LUT_AW-1:0] in_load_addr,
  output logic [BF16_W-1:0] in_load_data,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [BF16_W-1:0] x_data,
  output logic [BF16_W-1:0] input_x,
  output logic              input_x_valid,
  output logic              load_done,
  output logic              load_err,
  output state_t            dbg_state
);
  // Both streams use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; ready never depends on valid.
  localparam int ENT_W = $bits(lut_entry_t);
  localparam int CW    = $clog2(ENTRY_SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(ENTRY_SIZE - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_count;
  logic             w_accept;
  logic             w_restart;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [ENT_W-1:0] w_head;
  lut_entry_t       r_stg;
  logic             r_stg_vld;
  logic             w_drain_done;
  logic             w_err;

  assign w_accept     = s_valid && s_ready;
  assign w_restart    = start && ((r_state == ST_IDLE) || (r_state == ST_READY));
  assign w_pop        = !w_empty && !hold;
  assign w_drain_done = w_empty && (!r_stg_vld || !hold);
  assign dbg_state    = r_state;

  bf16_lut_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst_x),
    .i_clr   (w_restart),
    .i_push  (w_accept),
    .i_data  ({s_addr, s_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst_x) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOAD;
      ST_LOAD:  if (w_accept && (r_count == LAST)) w_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_done) w_next = w_err ? ST_IDLE : ST_READY;
      ST_READY: if (start) w_next = ST_LOAD;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready   = (r_state == ST_LOAD) && !w_full;
    x_ready   = (r_state == ST_READY);
    load_done = (r_state == ST_READY);
  end

  always_ff @(posedge clk) begin
    if (rst_x || w_restart) r_count <= '0;
    else if (w_accept)      r_count <= r_count + 1'b1;
  end

  // One register stage after the FIFO read gives the two-edge entry latency.
  always_ff @(posedge clk) begin
    if (rst_x || w_restart) begin
      r_stg_vld <= 1'b0;
      r_stg     <= '0;
    end else if (!hold) begin
      r_stg_vld <= w_pop;
      if (w_pop) r_stg <= lut_entry_t'(w_head);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_x) begin
      in_load_enable <= 1'b0;
      in_load_addr   <= '0;
      in_load_data   <= '0;
    end else begin
      in_load_enable <= r_stg_vld && !hold;
      if (r_stg_vld && !hold) begin
        in_load_addr <= r_stg.addr;
        in_load_data <= r_stg.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_x) begin
      input_x       <= '0;
      input_x_valid <= 1'b0;
    end else begin
      input_x_valid <= x_valid && x_ready;
      if (x_valid && x_ready) input_x <= x_data;
    end
  end

`ifdef BF16_LUT_COVER_EN
  logic [ENTRY_SIZE-1:0] r_mask;
  logic [ENTRY_SIZE-1:0] w_mask_next;
  logic                  r_err;

  assign w_mask_next = r_mask | (ENTRY_SIZE'(1) << s_addr);

  always_ff @(posedge clk) begin
    if (rst_x || w_restart) begin
      r_mask <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_mask <= w_mask_next;
      if ((r_count == LAST) && !(&w_mask_next)) r_err <= 1'b1;
    end
  end

  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  assign load_err = w_err;
endmodule

// File: tb/tb_bfloat16_lut_loader.sv
// Directed bench for bfloat16_lut_loader: full loads, hold back-pressure,
// sample forwarding, restart rules, mid-load reset and address coverage.
module tb_bfloat16_lut_loader;
  import bf16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_x, start, s_valid, s_ready, hold;
  logic [4:0]  s_addr, in_load_addr;
  logic [15:0] s_data, in_load_data, x_data, input_x;
  logic        in_load_enable, x_valid, x_ready, input_x_valid, load_done, load_err;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int n_acc    = 0;
  int cyc      = 0;
  int last_acc_cyc = 0;
  int first_wr_cyc = -1;
  logic [20:0] exp_q[$];

  bfloat16_lut_loader dut (
    .clk(clk), .rst_x(rst_x), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
    .hold(hold),
    .in_load_enable(in_load_enable), .in_load_addr(in_load_addr), .in_load_data(in_load_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .input_x(input_x), .input_x_valid(input_x_valid),
    .load_done(load_done), .load_err(load_err), .dbg_state(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every LUT write must match the oldest accepted entry.
  always @(negedge clk) begin
    if (in_load_enable === 1'b1) begin
      n_writes++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (exp_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
      else check("wr_order", {11'd0, in_load_addr, in_load_data}, {11'd0, exp_q.pop_front()});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_entry(input logic [4:0] a, input logic [15:0] d);
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_addr  = a;
    s_data  = d;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk);
      #1;
    end
    if (done) begin
      exp_q.push_back({a, d});
      n_acc++;
      last_acc_cyc = cyc;
    end else begin
      check("s_accept_timeout", 32'd0, 32'd1);
    end
    s_valid = 1'b0;
  endtask

  // Sends entries lo..hi with data 3f80+addr; index dup_idx reuses the previous address.
  task automatic load_seq(input int lo, input int hi, input int dup_idx);
    logic [4:0] a;
    for (int i = lo; i <= hi; i++) begin
      a = (i == dup_idx) ? 5'(i - 1) : 5'(i);
      send_entry(a, 16'h3f80 + 16'(a));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},   {31'd0, s_ready}, 32'd0);
    check({tag, "_x_ready"},   {31'd0, x_ready}, 32'd0);
    check({tag, "_ld_en"},     {31'd0, in_load_enable}, 32'd0);
    check({tag, "_ld_addr"},   {27'd0, in_load_addr}, 32'd0);
    check({tag, "_ld_data"},   {16'd0, in_load_data}, 32'd0);
    check({tag, "_input_x"},   {16'd0, input_x}, 32'd0);
    check({tag, "_x_valid"},   {31'd0, input_x_valid}, 32'd0);
    check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_load_err"},  {31'd0, load_err}, 32'd0);
    check({tag, "_state"},     32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int first_acc;
    int acc0;
    int wr0;
    rst_x = 1'b1; start = 1'b0; s_valid = 1'b0; s_addr = '0; s_data = '0;
    hold = 1'b0; x_valid = 1'b0; x_data = '0;
    step(2);
    check_all_zero("reset");
    rst_x = 1'b0;
    step(1);

    // Full back-to-back load of 32 entries
    pulse_start();
    check("start_state", 32'(dbg_state), 32'(ST_LOAD));
    check("start_s_ready", {31'd0, s_ready}, 32'd1);
    first_wr_cyc = -1;
    send_entry(5'd0, 16'h3f80);
    first_acc = last_acc_cyc;
    load_seq(1, 31, -1);
    step(1);
    check("done_k1", {31'd0, load_done}, 32'd0);
    step(1);
    check("done_k2", {31'd0, load_done}, 32'd1);
    check("ready_state", 32'(dbg_state), 32'(ST_READY));
    check("first_latency", 32'(first_wr_cyc - first_acc), 32'd2);
    step(1);
    check("writes_32", 32'(n_writes), 32'd32);
    check("queue_empty1", 32'(exp_q.size()), 32'd0);
    check("ld_en_idle", {31'd0, in_load_enable}, 32'd0);
    check("ld_addr_hold", {27'd0, in_load_addr}, 32'd31);
    check("ld_data_hold", {16'd0, in_load_data}, 32'h3f9f);

    // Sample forwarding in READY
    check("x_ready_on", {31'd0, x_ready}, 32'd1);
    x_valid = 1'b1; x_data = 16'h3f81;
    step(1);
    check("x1_data", {16'd0, input_x}, 32'h3f81);
    check("x1_valid", {31'd0, input_x_valid}, 32'd1);
    x_data = 16'h4001;
    step(1);
    check("x2_data", {16'd0, input_x}, 32'h4001);
    check("x2_valid", {31'd0, input_x_valid}, 32'd1);
    x_valid = 1'b0;
    step(1);
    check("x_valid_drop", {31'd0, input_x_valid}, 32'd0);
    check("x_data_keep", {16'd0, input_x}, 32'h4001);

    // Restart from READY
    pulse_start();
    check("restart_done", {31'd0, load_done}, 32'd0);
    check("restart_x_ready", {31'd0, x_ready}, 32'd0);
    check("restart_state", 32'(dbg_state), 32'(ST_LOAD));

    // Load with hold raised for 10 cycles after 8 entries
    acc0 = n_acc;
    fork
      load_seq(0, 31, -1);
      begin
        for (int t = 0; t < 500 && n_acc < acc0 + 8; t++) step(1);
        hold = 1'b1;
        step(10);
        @(negedge clk);
        check("hold_s_ready", {31'd0, s_ready}, 32'd0);
        check("hold_no_write", {31'd0, in_load_enable}, 32'd0);
        @(posedge clk);
        #1;
        hold = 1'b0;
      end
    join
    for (int t = 0; t < 30 && load_done !== 1'b1; t++) step(1);
    check("hold_done", {31'd0, load_done}, 32'd1);
    step(1);
    check("hold_queue_empty", 32'(exp_q.size()), 32'd0);
    check("hold_writes_64", 32'(n_writes), 32'd64);

    // start during DRAIN is ignored
    pulse_start();
    load_seq(0, 31, -1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("drain_ignore_start", 32'(dbg_state), 32'(ST_DRAIN));
    step(1);
    check("drain_to_ready", 32'(dbg_state), 32'(ST_READY));
    check("drain_done", {31'd0, load_done}, 32'd1);
    step(1);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset after 10 entries
    pulse_start();
    load_seq(0, 9, -1);
    rst_x = 1'b1;
    step(1);
    rst_x = 1'b0;
    check_all_zero("midrst");
    exp_q.delete();
    wr0 = n_writes;
    step(6);
    check("midrst_no_write", 32'(n_writes), 32'(wr0));

    // Address 5 sent twice, address 6 never
    pulse_start();
    load_seq(0, 31, 6);
    step(4);
`ifdef BF16_LUT_COVER_EN
    check("cov_err", {31'd0, load_err}, 32'd1);
    check("cov_done", {31'd0, load_done}, 32'd0);
    check("cov_state", 32'(dbg_state), 32'(ST_IDLE));
`else
    check("cov_err", {31'd0, load_err}, 32'd0);
    check("cov_done", {31'd0, load_done}, 32'd1);
    check("cov_state", 32'(dbg_state), 32'(ST_READY));
`endif
    check("cov_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bfloat16_lut_loader.md
BFLOAT16_LUT_LOADER -- requirements
Module: bfloat16_lut_loader

Interface
REQ-001 Parameter ENTRY_SIZE, default 32, number of LUT entries per load sequence.
REQ-002 Parameter FIFO_DEPTH, default 4, entry-buffer depth (power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_x  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a LUT load sequence.
REQ-006 s_valid  input  1  load-entry stream valid.
REQ-007 s_ready  output  1  load-entry stream ready.
REQ-008 s_addr  input  5  LUT entry address.
REQ-009 s_data  input  16  LUT entry value (bfloat16).
REQ-010 hold  input  1  downstream pause; no LUT write issued while high.
REQ-011 in_load_enable  output  1  LUT write strobe to bfloat16_tanh.
REQ-012 in_load_addr  output  5  LUT write address to bfloat16_tanh.
REQ-013 in_load_data  output  16  LUT write data to bfloat16_tanh.
REQ-014 x_valid  input  1  sample stream valid.
REQ-015 x_ready  output  1  sample stream ready.
REQ-016 x_data  input  16  bfloat16 sample.
REQ-017 input_x  output  16  registered sample to bfloat16_tanh.
REQ-018 input_x_valid  output  1  one-cycle pulse, input_x updated this cycle.
REQ-019 load_done  output  1  LUT fully loaded; level.
REQ-020 load_err  output  1  coverage failure; level, cleared by start or reset.

Function
REQ-021 States IDLE, LOAD, DRAIN, READY; reset state IDLE.
REQ-022 IDLE: s_ready=0, x_ready=0; start -> LOAD, clearing entry counter, FIFO, load_err.
REQ-023 LOAD: s_ready = FIFO not full; entry accepted on s_valid&&s_ready; counter increments per acceptance.
REQ-024 LOAD -> DRAIN on the edge accepting entry number ENTRY_SIZE; s_ready=0 from next cycle.
REQ-025 Each cycle FIFO non-empty and hold=0: pop one entry, registered onto in_load_* with in_load_enable=1 for exactly one cycle.
REQ-026 Latency: entry accepted at edge k with empty FIFO and hold=0 appears on in_load_* after edge k+2; order preserved; throughput one entry per cycle.
REQ-027 in_load_enable=0 whenever no pop occurred; in_load_addr/data hold last value.
REQ-028 DRAIN -> READY when FIFO empty and final write issued; load_done=1 from that edge.
REQ-029 READY: x_ready=1; on x_valid, input_x <= x_data, input_x_valid pulses next cycle.
REQ-030 start in READY or IDLE restarts load (-> LOAD, load_done=0, x_ready=0 next cycle); start in LOAD/DRAIN ignored.
REQ-031 hold high in DRAIN stalls transition; FIFO full in LOAD forces s_ready=0, no entry lost.
REQ-032 Simultaneous push and pop in same cycle on full FIFO permitted only when pop occurs; occupancy unchanged.

Reset
REQ-033 rst_x high at an edge: state IDLE, FIFO empty, counter 0, all outputs 0 (input_x=16'h0000, in_load_addr=0, in_load_data=0).
REQ-034 Reset mid-LOAD discards buffered entries; no in_load_enable pulse after the reset edge.

Configuration
REQ-035 Macro BF16_LUT_COVER_EN: when defined, a ENTRY_SIZE-bit written-address mask; after count reaches ENTRY_SIZE with mask incomplete, load_err=1, state -> IDLE after drain, load_done stays 0.
REQ-036 Without BF16_LUT_COVER_EN: completion by count only; load_err tied 0.

Structure
REQ-037 Shared package bf16_pkg holds bfloat16 width constant, LUT address width, ENTRY_SIZE default, state encoding.
REQ-038 One sub-module bf16_lut_fifo (synchronous FIFO, push/pop/full/empty).

Verification
REQ-039 Reset, start, 32 entries addr 0..31 data 16'h3f80+addr back-to-back, hold=0 -> 32 in_load_enable pulses in order, load_done=1 two cycles after last acceptance.
REQ-040 hold=1 for 10 cycles mid-load -> s_ready drops after 4 buffered entries, no entry lost or duplicated, order intact.
REQ-041 READY, x_data=16'h3f81 then 16'h4001 -> input_x matches each one cycle later with input_x_valid pulses.
REQ-042 rst_x asserted after 10 entries -> all outputs 0 next cycle, no further in_load_enable.
REQ-043 BF16_LUT_COVER_EN, addr 5 sent twice, addr 6 never -> load_err=1, load_done=0; without macro -> load_done=1.
REQ-044 start asserted in DRAIN -> ignored; start in READY -> load_done=0, x_ready=0 next cycle.
